// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the 5-stage pipeline hazard sequencer:
// register-index width, PC index, forwarding selects and FSM states.
package hazard_sequencer_pkg;

  localparam int REG_W  = 4;
  localparam int PC_IDX = 15;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b,
                                     input logic             en);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/hazard_sequencer_fwd_select.sv
// Per-operand comparator: forwarding select and load-use detect for one
// ID-stage source register.
module hazard_sequencer_fwd_select
  import hazard_sequencer_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_rf_en,
  input  logic             i_ex_load,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_rf_en,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_rf_en,
  output fwd_e             o_fwd,
  output logic             o_lu
);

  logic w_live;

  // The PC is never held in a pipeline register, so it is never forwarded.
  assign w_live = i_use && (i_src != REG_W'(PC_IDX));

  always_comb begin
    o_fwd = FWD_RF;
    if (w_live && reg_match(i_mem_rd, i_src, i_mem_rf_en)) begin
      o_fwd = FWD_EXMEM;
    end else if (w_live && reg_match(i_wb_rd, i_src, i_wb_rf_en)) begin
      o_fwd = FWD_MEMWB;
    end
  end

  assign o_lu = w_live && i_ex_load && reg_match(i_ex_rd, i_src, i_ex_rf_en);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control: operand forwarding, load-use stall, branch flush and
// whole-pipeline freeze while data memory is busy, with stall/timeout tracking.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rs,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_rf_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_rf_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd_rn,
  output logic [1:0]       fwd_rm,
  output logic [1:0]       fwd_rs,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int                WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic [REG_W-1:0] w_src [3];
  logic             w_use [3];
  fwd_e             w_fwd [3];
  logic [2:0]       w_lu;
  logic             w_lu_any;
  logic             w_mem_stall;

  state_e            r_state, w_state_next;
  logic              r_pending, w_pending_next;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_timeout;

  assign w_src[0] = id_rn;
  assign w_src[1] = id_rm;
  assign w_src[2] = id_rs;
  assign w_use[0] = id_use_rn;
  assign w_use[1] = id_use_rm;
  assign w_use[2] = id_use_rs;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_opnd
      hazard_sequencer_fwd_select u_fwd (
        .i_src      (w_src[gi]),
        .i_use      (w_use[gi]),
        .i_ex_rd    (ex_rd),
        .i_ex_rf_en (ex_rf_en),
        .i_ex_load  (ex_load),
        .i_mem_rd   (mem_rd),
        .i_mem_rf_en(mem_rf_en),
        .i_wb_rd    (wb_rd),
        .i_wb_rf_en (wb_rf_en),
        .o_fwd      (w_fwd[gi]),
        .o_lu       (w_lu[gi])
      );
    end
  endgenerate

  assign w_lu_any    = |w_lu;
  assign w_mem_stall = mem_req && !mem_ready;

  // Reset forces the idle view on every combinational output.
  assign fwd_rn = reset ? FWD_RF : w_fwd[0];
  assign fwd_rm = reset ? FWD_RF : w_fwd[1];
  assign fwd_rs = reset ? FWD_RF : w_fwd[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pending   <= 1'b0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pending_next;
      r_wait_cnt <= w_wait_next;
      if (!pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_wait_next == WAIT_LIM) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_wait_next    = r_wait_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_state_next = ST_WAIT;
          w_wait_next  = WAIT_W'(1);
          if (branch_taken) w_pending_next = 1'b1;
        end else if (branch_taken || r_pending) begin
          w_pending_next = 1'b0;
        end
      end
      ST_WAIT: begin
        // A branch resolved during the freeze is remembered for the first RUN cycle.
        if (branch_taken) w_pending_next = 1'b1;
        if (mem_ready) begin
          w_state_next = ST_RUN;
        end else if (r_wait_cnt < WAIT_LIM) begin
          w_wait_next = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          end else if (branch_taken || r_pending) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_lu_any) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        ST_WAIT: begin
          if (!mem_ready) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed test-plan sequences plus
// biased random traffic, checked against a rule-level reference model.
module tb_hazard_sequencer;
  import hazard_sequencer_pkg::*;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [3:0] id_rn, id_rm, id_rs, ex_rd, mem_rd, wb_rd;
  logic id_use_rn, id_use_rm, id_use_rs, ex_rf_en, ex_load, mem_rf_en, wb_rf_en;
  logic branch_taken, mem_req, mem_ready;
  logic [1:0] fwd_rn, fwd_rm, fwd_rs;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic mem_timeout;

  hazard_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .fwd_rn(fwd_rn), .fwd_rm(fwd_rm), .fwd_rs(fwd_rs),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic       reset;
    logic [3:0] rn, rm, rs;
    logic       use_rn, use_rm, use_rs;
    logic [3:0] ex_rd;
    logic       ex_rf_en, ex_load;
    logic [3:0] mem_rd;
    logic       mem_rf_en;
    logic [3:0] wb_rd;
    logic       wb_rf_en;
    logic       branch, mem_req, mem_ready;
  } stim_t;

  typedef struct packed {
    logic [5:0]  fwd;     // {rn, rm, rs}
    logic [4:0]  en;      // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic        flush;
    logic        bubble;
    logic [15:0] stall;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model: "frozen" flag, owed flush, length of current freeze.
  bit m_frozen, m_owed, m_timeout;
  int m_freeze_len, m_stalls;

  function automatic logic [1:0] ref_fwd(input logic [3:0] src, input logic used, input stim_t s);
    if (!used || src == 4'd15) return 2'b00;
    if (s.mem_rf_en && s.mem_rd == src) return 2'b01;
    if (s.wb_rf_en && s.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_lu(input logic [3:0] src, input logic used, input stim_t s);
    return used && src != 4'd15 && s.ex_load && s.ex_rf_en && s.ex_rd == src;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [3:0] rreg();
    int k;
    k = $urandom_range(0, 5);
    if (k == 5) return 4'd15;
    if (k == 4) return 4'($urandom_range(0, 15));
    return 4'(k);
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = '0;
    s.reset     = ($urandom_range(0, 199) == 0);
    s.rn        = rreg();
    s.rm        = rreg();
    s.rs        = rreg();
    s.use_rn    = ($urandom_range(0, 3) != 0);
    s.use_rm    = ($urandom_range(0, 3) != 0);
    s.use_rs    = ($urandom_range(0, 3) != 0);
    s.ex_rd     = rreg();
    s.ex_rf_en  = ($urandom_range(0, 3) != 0);
    s.ex_load   = ($urandom_range(0, 2) == 0);
    s.mem_rd    = rreg();
    s.mem_rf_en = $urandom_range(0, 1) == 1;
    s.wb_rd     = rreg();
    s.wb_rf_en  = $urandom_range(0, 1) == 1;
    s.branch    = ($urandom_range(0, 5) == 0);
    s.mem_req   = ($urandom_range(0, 3) == 0);
    s.mem_ready = $urandom_range(0, 1) == 1;
    return s;
  endfunction

  task automatic model_reset();
    m_frozen = 0; m_owed = 0; m_timeout = 0; m_freeze_len = 0; m_stalls = 0;
  endtask

  task automatic apply(input stim_t s);
    reset = s.reset;
    id_rn = s.rn; id_rm = s.rm; id_rs = s.rs;
    id_use_rn = s.use_rn; id_use_rm = s.use_rm; id_use_rs = s.use_rs;
    ex_rd = s.ex_rd; ex_rf_en = s.ex_rf_en; ex_load = s.ex_load;
    mem_rd = s.mem_rd; mem_rf_en = s.mem_rf_en;
    wb_rd = s.wb_rd; wb_rf_en = s.wb_rf_en;
    branch_taken = s.branch; mem_req = s.mem_req; mem_ready = s.mem_ready;
  endtask

  // Drive one cycle of stimulus and queue what the DUT should show during it.
  task automatic drive(input stim_t s);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    apply(s);
    if (s.reset) model_reset();
    e.stall   = 16'(m_stalls);
    e.timeout = m_timeout;
    e.fwd     = {ref_fwd(s.rn, s.use_rn, s), ref_fwd(s.rm, s.use_rm, s), ref_fwd(s.rs, s.use_rs, s)};
    e.en      = 5'b11111;
    e.flush   = 1'b0;
    e.bubble  = 1'b0;
    lu = ref_lu(s.rn, s.use_rn, s) || ref_lu(s.rm, s.use_rm, s) || ref_lu(s.rs, s.use_rs, s);
    if (s.reset) begin
      e.fwd = '0;
    end else if (!m_frozen) begin
      if (s.mem_req && !s.mem_ready) begin
        e.en = '0;
        m_frozen = 1; m_freeze_len = 1;
        if (s.branch) m_owed = 1;
      end else if (s.branch || m_owed) begin
        e.flush = 1'b1; e.bubble = 1'b1; m_owed = 0;
      end else if (lu) begin
        e.en[4] = 1'b0; e.en[3] = 1'b0; e.bubble = 1'b1;
      end
    end else begin
      if (s.branch) m_owed = 1;
      if (s.mem_ready) begin
        m_frozen = 0;
      end else begin
        e.en = '0;
        if (m_freeze_len < WAIT_MAX) m_freeze_len++;
      end
    end
    if (!s.reset) begin
      if (m_freeze_len == WAIT_MAX) m_timeout = 1;
      if (!e.en[4] && m_stalls < 65535) m_stalls++;
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s txn %0d got %0h expected %0h", name, txn, got, want);
    end
  endtask

  // Monitor: one popped expectation per cycle, compared mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd", 32'({fwd_rn, fwd_rm, fwd_rs}), 32'(e.fwd));
        check("enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e.en));
        check("flush_bubble", 32'({if_id_flush, id_ex_bubble}), 32'({e.flush, e.bubble}));
        check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        check("mem_timeout", 32'(mem_timeout), 32'(e.timeout));
        $display("txn %0d rst=%0b fwd=%b en=%b fl=%0b bb=%0b stall=%0d to=%0b",
                 txn, reset, {fwd_rn, fwd_rm, fwd_rs},
                 {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
                 if_id_flush, id_ex_bubble, stall_cnt, mem_timeout);
        txn++;
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    s = idle();
    s.reset = 1'b1;
    apply(s);
    model_reset();
    repeat (3) drive(s);
    repeat (2) drive(idle());

    // Forwarding priority and PC exclusion
    s = idle();
    s.mem_rd = 4'd3; s.mem_rf_en = 1; s.wb_rd = 4'd3; s.wb_rf_en = 1;
    s.rn = 4'd3; s.use_rn = 1;
    drive(s);
    s.mem_rf_en = 0;
    drive(s);
    s.rn = 4'd15; s.mem_rd = 4'd15; s.wb_rd = 4'd15; s.mem_rf_en = 1;
    drive(s);

    // Load-use stall then forward from EX/MEM
    s = idle();
    s.ex_load = 1; s.ex_rf_en = 1; s.ex_rd = 4'd5; s.rm = 4'd5; s.use_rm = 1;
    drive(s);
    s = idle();
    s.mem_rd = 4'd5; s.mem_rf_en = 1; s.rm = 4'd5; s.use_rm = 1;
    drive(s);

    // Memory freeze with a branch arriving mid-freeze
    s = idle();
    s.mem_req = 1;
    drive(s);
    s.branch = 1;
    drive(s);
    s.branch = 0;
    drive(s);
    s.mem_ready = 1;
    drive(s);
    repeat (3) drive(idle());

    // Branch coincident with load-use: flush wins
    s = idle();
    s.ex_load = 1; s.ex_rf_en = 1; s.ex_rd = 4'd7; s.rs = 4'd7; s.use_rs = 1; s.branch = 1;
    drive(s);
    drive(idle());

    // Long freeze reaches the timeout, which stays sticky
    s = idle();
    s.mem_req = 1;
    repeat (20) drive(s);
    s.mem_ready = 1;
    drive(s);
    repeat (2) drive(idle());

    // Reset during a freeze with an owed flush
    s = idle();
    s.mem_req = 1;
    drive(s);
    s.branch = 1;
    drive(s);
    s.branch = 0;
    drive(s);
    s.reset = 1;
    drive(s);
    repeat (3) drive(idle());

    repeat (800) drive(rnd());
    repeat (2) drive(idle());

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
